// File: rtl/sap_ctrl_seq_if.sv
// Control bundle between the SAP sequencer (master) and the datapath (slave).
// SAP_CTRL_STEP_EN adds the single-step request line.
interface sap_ctrl_seq_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] opcode;
  logic           flag_c;
  logic           flag_z;
`ifdef SAP_CTRL_STEP_EN
  logic           step;
`endif
  logic           pc_inc;
  logic           pc_write;
  logic           pc_out_en;
  logic           mar_load;
  logic           ram_out_en;
  logic           ram_write;
  logic           ir_load;
  logic           ir_out_en;
  logic           a_load;
  logic           a_out_en;
  logic           b_load;
  logic           alu_out_en;
  logic           alu_sub;
  logic           flags_load;
  logic           out_load;
  logic           halted;
  logic [2:0]     tstate;

  modport master (
`ifdef SAP_CTRL_STEP_EN
    input  step,
`endif
    input  opcode, flag_c, flag_z,
    output pc_inc, pc_write, pc_out_en, mar_load, ram_out_en, ram_write,
           ir_load, ir_out_en, a_load, a_out_en, b_load, alu_out_en,
           alu_sub, flags_load, out_load, halted, tstate
  );

  modport slave (
`ifdef SAP_CTRL_STEP_EN
    output step,
`endif
    output opcode, flag_c, flag_z,
    input  pc_inc, pc_write, pc_out_en, mar_load, ram_out_en, ram_write,
           ir_load, ir_out_en, a_load, a_out_en, b_load, alu_out_en,
           alu_sub, flags_load, out_load, halted, tstate
  );
endinterface

// File: rtl/sap_ctrl_seq.sv
// SAP fetch/decode/execute sequencer: T-state ring plus opcode decode into bus strobes; no backpressure.
// Strobes registered from next-state decode (T2 decodes live IR/flags); SAP_CTRL_STEP_EN adds a WAIT gate before T0.
module sap_ctrl_seq #(
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] HLT_OP = OPW'(4'hF)
) (
  input logic            clk,
  input logic            rst,
  sap_ctrl_seq_if.master ctl
);

  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);

  typedef enum logic [2:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_HALT, S_WAIT
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_write;
    logic pc_out_en;
    logic mar_load;
    logic ram_out_en;
    logic ram_write;
    logic ir_load;
    logic ir_out_en;
    logic a_load;
    logic a_out_en;
    logic b_load;
    logic alu_out_en;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } strb_t;

  state_t         state_q, state_d;
  strb_t          strb_q, strb_d, t2_strb, strb;
  logic [2:0]     tstate_q, tstate_d;
  logic           halted_q;
  logic           step;
  logic [OPW-1:0] opcode;
  logic           is_alu, is_mem;

`ifdef SAP_CTRL_STEP_EN
  localparam state_t S_NEXT = S_WAIT;
  assign step = ctl.step;
`else
  localparam state_t S_NEXT = S_T0;
  assign step = 1'b0;
`endif

  assign opcode = ctl.opcode;
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_mem = is_alu || (opcode == OP_LDA) || (opcode == OP_STA);

  always_comb begin
    state_d  = state_q;
    strb_d   = '0;
    t2_strb  = '0;
    tstate_d = 3'd0;

    case (state_q)
      S_RST:   state_d = S_NEXT;
      S_WAIT:  if (step) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        if (opcode == HLT_OP) state_d = S_HALT;
        else if (is_mem)      state_d = S_T3;
        else                  state_d = S_NEXT;
      end
      S_T3:    state_d = is_alu ? S_T4 : S_NEXT;
      S_T4:    state_d = S_NEXT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase

    // Strobes for the state being entered; T3/T4 use the IR already loaded during T1.
    case (state_d)
      S_T0: begin
        tstate_d         = 3'd0;
        strb_d.pc_out_en = 1'b1;
        strb_d.mar_load  = 1'b1;
      end
      S_T1: begin
        tstate_d          = 3'd1;
        strb_d.ram_out_en = 1'b1;
        strb_d.ir_load    = 1'b1;
        strb_d.pc_inc     = 1'b1;
      end
      S_T2: tstate_d = 3'd2;
      S_T3: begin
        tstate_d = 3'd3;
        if (opcode == OP_LDA) begin
          strb_d.ram_out_en = 1'b1;
          strb_d.a_load     = 1'b1;
        end else if (is_alu) begin
          strb_d.ram_out_en = 1'b1;
          strb_d.b_load     = 1'b1;
        end else if (opcode == OP_STA) begin
          strb_d.a_out_en  = 1'b1;
          strb_d.ram_write = 1'b1;
        end
      end
      S_T4: begin
        tstate_d          = 3'd4;
        strb_d.alu_out_en = 1'b1;
        strb_d.a_load     = 1'b1;
        strb_d.flags_load = 1'b1;
        strb_d.alu_sub    = (opcode == OP_SUB);
      end
      S_HALT:  tstate_d = 3'd5;
      S_WAIT:  tstate_d = 3'd6;
      default: tstate_d = 3'd0;
    endcase

    // The opcode only exists once IR has loaded, so T2 decodes the IR/flag registers directly.
    if ((state_q == S_T2) && (opcode != HLT_OP)) begin
      if (is_mem) begin
        t2_strb.ir_out_en = 1'b1;
        t2_strb.mar_load  = 1'b1;
      end else if (opcode == OP_LDI) begin
        t2_strb.ir_out_en = 1'b1;
        t2_strb.a_load    = 1'b1;
      end else if ((opcode == OP_JMP) || ((opcode == OP_JC) && ctl.flag_c) ||
                   ((opcode == OP_JZ) && ctl.flag_z)) begin
        t2_strb.ir_out_en = 1'b1;
        t2_strb.pc_write  = 1'b1;
      end else if (opcode == OP_OUT) begin
        t2_strb.a_out_en = 1'b1;
        t2_strb.out_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RST;
      strb_q   <= '0;
      tstate_q <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      tstate_q <= tstate_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  assign strb = strb_q | t2_strb;

  assign ctl.pc_inc     = strb.pc_inc;
  assign ctl.pc_write   = strb.pc_write;
  assign ctl.pc_out_en  = strb.pc_out_en;
  assign ctl.mar_load   = strb.mar_load;
  assign ctl.ram_out_en = strb.ram_out_en;
  assign ctl.ram_write  = strb.ram_write;
  assign ctl.ir_load    = strb.ir_load;
  assign ctl.ir_out_en  = strb.ir_out_en;
  assign ctl.a_load     = strb.a_load;
  assign ctl.a_out_en   = strb.a_out_en;
  assign ctl.b_load     = strb.b_load;
  assign ctl.alu_out_en = strb.alu_out_en;
  assign ctl.alu_sub    = strb.alu_sub;
  assign ctl.flags_load = strb.flags_load;
  assign ctl.out_load   = strb.out_load;
  assign ctl.halted     = halted_q;
  assign ctl.tstate     = tstate_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed-vector bench for sap_ctrl_seq: per-instruction strobe tables, random bus-driver invariants, HALT and reset.
// Define SAP_CTRL_STEP_EN for both RTL and bench to exercise single-step mode.
module tb_sap_ctrl_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sap_ctrl_seq_if #(.OPW(4)) ctl();

  sap_ctrl_seq #(.OPW(4), .HLT_OP(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  localparam logic [14:0] PC_INC     = 15'h4000;
  localparam logic [14:0] PC_WRITE   = 15'h2000;
  localparam logic [14:0] PC_OUT     = 15'h1000;
  localparam logic [14:0] MAR_LOAD   = 15'h0800;
  localparam logic [14:0] RAM_OUT    = 15'h0400;
  localparam logic [14:0] RAM_WRITE  = 15'h0200;
  localparam logic [14:0] IR_LOAD    = 15'h0100;
  localparam logic [14:0] IR_OUT     = 15'h0080;
  localparam logic [14:0] A_LOAD     = 15'h0040;
  localparam logic [14:0] A_OUT      = 15'h0020;
  localparam logic [14:0] B_LOAD     = 15'h0010;
  localparam logic [14:0] ALU_OUT    = 15'h0008;
  localparam logic [14:0] ALU_SUB    = 15'h0004;
  localparam logic [14:0] FLAGS_LOAD = 15'h0002;
  localparam logic [14:0] OUT_LOAD   = 15'h0001;
  localparam logic [14:0] T0_EXP     = PC_OUT | MAR_LOAD;
  localparam logic [14:0] T1_EXP     = RAM_OUT | IR_LOAD | PC_INC;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        fc;
    logic        fz;
    int          len;
    logic [14:0] t2;
    logic [14:0] t3;
    logic [14:0] t4;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [14:0] strobes();
    return {ctl.pc_inc, ctl.pc_write, ctl.pc_out_en, ctl.mar_load, ctl.ram_out_en,
            ctl.ram_write, ctl.ir_load, ctl.ir_out_en, ctl.a_load, ctl.a_out_en,
            ctl.b_load, ctl.alu_out_en, ctl.alu_sub, ctl.flags_load, ctl.out_load};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction boundary: T0 directly, or WAIT in single-step builds.
  task automatic chk_idle(input string name);
`ifdef SAP_CTRL_STEP_EN
    chk({name, "_ts"}, 32'(ctl.tstate), 32'd6);
    chk({name, "_strb"}, 32'(strobes()), 32'd0);
`else
    chk({name, "_ts"}, 32'(ctl.tstate), 32'd0);
    chk({name, "_strb"}, 32'(strobes()), 32'(T0_EXP));
`endif
  endtask

  function automatic bit at_idle();
`ifdef SAP_CTRL_STEP_EN
    return ctl.tstate == 3'd6;
`else
    return (ctl.tstate == 3'd0) && ctl.pc_out_en;
`endif
  endfunction

  task automatic start_instr();
`ifdef SAP_CTRL_STEP_EN
    ctl.step = 1'b1;
    @(negedge clk);
    ctl.step = 1'b0;
`endif
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic fc, input logic fz,
                         input int len, input logic [14:0] t2, input logic [14:0] t3,
                         input logic [14:0] t4);
    vec_t v;
    v.name = name; v.op = op; v.fc = fc; v.fz = fz; v.len = len;
    v.t2 = t2; v.t3 = t3; v.t4 = t4;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic [14:0] exp [5];
    exp[0] = T0_EXP; exp[1] = T1_EXP; exp[2] = v.t2; exp[3] = v.t3; exp[4] = v.t4;
    ctl.opcode = v.op;
    ctl.flag_c = v.fc;
    ctl.flag_z = v.fz;
    start_instr();
    for (int k = 0; k < v.len; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s_t%0d_strb", v.name, k), 32'(strobes()), 32'(exp[k]));
      chk($sformatf("%s_t%0d_ts", v.name, k), 32'(ctl.tstate), 32'(k));
    end
    chk({v.name, "_halted"}, 32'(ctl.halted), 32'd0);
    @(negedge clk);
    chk_idle({v.name, "_end"});
  endtask

  initial begin
    int n;
    int cyc;
    int errs;
    int drv;
    logic [14:0] s;

    add_vec("nop_a",   4'h0, 1'b0, 1'b0, 3, 15'h0, 15'h0, 15'h0);
    add_vec("nop_b",   4'h0, 1'b0, 1'b0, 3, 15'h0, 15'h0, 15'h0);
    add_vec("lda",     4'h1, 1'b0, 1'b0, 4, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, 15'h0);
    add_vec("add",     4'h2, 1'b0, 1'b0, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
            ALU_OUT | A_LOAD | FLAGS_LOAD);
    add_vec("sub",     4'h3, 1'b0, 1'b0, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
            ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB);
    add_vec("sta",     4'h4, 1'b0, 1'b0, 4, IR_OUT | MAR_LOAD, A_OUT | RAM_WRITE, 15'h0);
    add_vec("ldi",     4'h5, 1'b0, 1'b0, 3, IR_OUT | A_LOAD, 15'h0, 15'h0);
    add_vec("jmp",     4'h6, 1'b0, 1'b0, 3, IR_OUT | PC_WRITE, 15'h0, 15'h0);
    add_vec("jc_c0",   4'h7, 1'b0, 1'b0, 3, 15'h0, 15'h0, 15'h0);
    add_vec("jc_c1",   4'h7, 1'b1, 1'b0, 3, IR_OUT | PC_WRITE, 15'h0, 15'h0);
    add_vec("jc_z1",   4'h7, 1'b0, 1'b1, 3, 15'h0, 15'h0, 15'h0);
    add_vec("jz_z0",   4'h8, 1'b0, 1'b0, 3, 15'h0, 15'h0, 15'h0);
    add_vec("jz_z1",   4'h8, 1'b0, 1'b1, 3, IR_OUT | PC_WRITE, 15'h0, 15'h0);
    add_vec("jz_c1",   4'h8, 1'b1, 1'b0, 3, 15'h0, 15'h0, 15'h0);
    add_vec("undef9",  4'h9, 1'b1, 1'b1, 3, 15'h0, 15'h0, 15'h0);
    add_vec("undefD",  4'hD, 1'b1, 1'b1, 3, 15'h0, 15'h0, 15'h0);
    add_vec("out",     4'hE, 1'b0, 1'b0, 3, A_OUT | OUT_LOAD, 15'h0, 15'h0);
    add_vec("sub_c1",  4'h3, 1'b1, 1'b1, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
            ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB);

    rst = 1'b0;
    ctl.opcode = 4'h0;
    ctl.flag_c = 1'b0;
    ctl.flag_z = 1'b0;
`ifdef SAP_CTRL_STEP_EN
    ctl.step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_strb", 32'(strobes()), 32'd0);
    chk("rst_ts", 32'(ctl.tstate), 32'd0);
    chk("rst_halted", 32'(ctl.halted), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    chk_idle("release");
`ifdef SAP_CTRL_STEP_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_idle($sformatf("wait_hold%0d", i));
    end
`endif

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

    // Random opcodes (no HLT): bus-driver exclusivity and MAR/RAM write separation.
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      s = strobes();
      drv = 32'(ctl.pc_out_en) + 32'(ctl.ram_out_en) + 32'(ctl.ir_out_en) +
            32'(ctl.a_out_en) + 32'(ctl.alu_out_en);
      chk("rand_onehot_drv", 32'(drv <= 1), 32'd1);
      chk("rand_mar_ramwr", 32'(s[11] & s[9]), 32'd0);
`ifdef SAP_CTRL_STEP_EN
      ctl.step = 1'b0;
`endif
      if (at_idle()) begin
        n++;
        ctl.opcode = 4'($urandom_range(0, 14));
        ctl.flag_c = 1'($urandom_range(0, 1));
        ctl.flag_z = 1'($urandom_range(0, 1));
`ifdef SAP_CTRL_STEP_EN
        ctl.step = 1'b1;
`endif
      end
      @(negedge clk);
      cyc++;
    end
`ifdef SAP_CTRL_STEP_EN
    ctl.step = 1'b0;
`endif
    chk("rand_instr_count", 32'(n), 32'd1000);
    for (int i = 0; i < 10 && !at_idle(); i++) @(negedge clk);
    chk_idle("rand_drain");

    // HALT, then an asynchronous reset pulse mid-halt.
    ctl.opcode = 4'hF;
    start_instr();
    chk("hlt_t0", 32'(strobes()), 32'(T0_EXP));
    @(negedge clk);
    chk("hlt_t1", 32'(strobes()), 32'(T1_EXP));
    @(negedge clk);
    chk("hlt_t2_strb", 32'(strobes()), 32'd0);
    chk("hlt_t2_ts", 32'(ctl.tstate), 32'd2);
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (!(ctl.halted === 1'b1 && ctl.tstate === 3'd5 && strobes() === 15'h0)) errs++;
    end
    chk("halt_hold_errs", 32'(errs), 32'd0);
    chk("halt_flag", 32'(ctl.halted), 32'd1);
    chk("halt_ts", 32'(ctl.tstate), 32'd5);

    ctl.opcode = 4'h0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_halted", 32'(ctl.halted), 32'd0);
    chk("async_rst_ts", 32'(ctl.tstate), 32'd0);
    chk("async_rst_strb", 32'(strobes()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("restart");
    chk("restart_halted", 32'(ctl.halted), 32'd0);
    run_vec(vq[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
